// File: rtl/cnt_mod_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnt_mod_pkg : channel state encoding and mode constants for cnt_mod     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package cnt_mod_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cnt_mod_ch.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnt_mod_ch : one counter channel (IDLE/RUN/DONE) with shadowed n/cmp    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cnt_mod_ch
  import cnt_mod_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         exec,
  input  logic         mode,
  input  logic [W-1:0] n,
  input  logic [W-1:0] cmp,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         tc,
  output logic         match
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]   state_q,  state_d;
  logic [W-1:0] cnt_q,    cnt_d;
  logic [W-1:0] n_l_q,    n_l_d;
  logic [W-1:0] cmp_l_q,  cmp_l_d;
  logic         mode_l_q, mode_l_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      n_l_q    <= '0;
      cmp_l_q  <= '0;
      mode_l_q <= MODE_WRAP;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_l_q    <= n_l_d;
      cmp_l_q  <= cmp_l_d;
      mode_l_q <= mode_l_d;
    end
  end

  // Dropping exec in RUN is checked before terminal handling so it wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_l_d    = n_l_q;
    cmp_l_d  = cmp_l_q;
    mode_l_d = mode_l_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exec) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            n_l_d    = n;
            cmp_l_d  = cmp;
            mode_l_d = mode;
          end
        end
        ST_RUN: begin
          if (!exec) begin
            state_d = ST_IDLE;
          end else if (cnt_q == n_l_q) begin
            if (mode_l_q == MODE_ONESHOT) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = '0;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_DONE: begin
          if (!exec) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt   = cnt_q;
    busy  = (state_q == ST_RUN);
    tc    = (state_q == ST_RUN) && (cnt_q == n_l_q);
    match = (state_q == ST_RUN) && (cnt_q == cmp_l_q);
  end

endmodule
`default_nettype wire

// File: rtl/cnt_mod_multi.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnt_mod_multi : CH independent counter channels on packed buses         |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cnt_mod_multi
  import cnt_mod_pkg::*;
#(
  parameter int W  = 32,
  parameter int CH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic [CH-1:0] exec,
  input  logic [CH-1:0] mode,
  input  logic [CH*W-1:0] n,
  input  logic [CH*W-1:0] cmp,
  output logic [CH*W-1:0] cnt,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] tc,
  output logic [CH-1:0] match
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    cnt_mod_ch #(
      .W(W)
    ) u_ch (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .exec (exec[i]),
      .mode (mode[i]),
      .n    (n[i*W +: W]),
      .cmp  (cmp[i*W +: W]),
      .cnt  (cnt[i*W +: W]),
      .busy (busy[i]),
      .tc   (tc[i]),
      .match(match[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_cnt_mod_multi.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_cnt_mod_multi : directed and random stimulus against a channel model |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_cnt_mod_multi;

  localparam int W  = 8;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            clr;
  logic [CH-1:0]   exec;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] n;
  logic [CH*W-1:0] cmp;
  logic [CH*W-1:0] cnt;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   tc;
  logic [CH-1:0]   match;

  int checks = 0;
  int errors = 0;
  bit sim_done = 1'b0;

  cnt_mod_multi #(.W(W), .CH(CH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .exec (exec),
    .mode (mode),
    .n    (n),
    .cmp  (cmp),
    .cnt  (cnt),
    .busy (busy),
    .tc   (tc),
    .match(match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %0d, expected %0d at %0t", name, c, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=running 2=finished, plus the values captured at start.
  int          m_ph   [CH];
  int unsigned m_cnt  [CH];
  int unsigned m_n    [CH];
  int unsigned m_cmp  [CH];
  bit          m_shot [CH];

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_ph[c] = 0; m_cnt[c] = 0; m_n[c] = 0; m_cmp[c] = 0; m_shot[c] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!rstn) begin
        m_ph[c] = 0; m_cnt[c] = 0; m_n[c] = 0; m_cmp[c] = 0; m_shot[c] = 1'b0;
      end else if (clr) begin
        m_ph[c] = 0; m_cnt[c] = 0;
      end else if (m_ph[c] == 0) begin
        if (exec[c]) begin
          m_ph[c]   = 1;
          m_cnt[c]  = 0;
          m_n[c]    = n[c*W +: W];
          m_cmp[c]  = cmp[c*W +: W];
          m_shot[c] = mode[c];
        end
      end else if (!exec[c]) begin
        m_ph[c] = 0;
      end else if (m_ph[c] == 1) begin
        if (m_shot[c] && m_cnt[c] == m_n[c]) m_ph[c] = 2;
        else m_cnt[c] = (m_cnt[c] + 1) % (m_n[c] + 1);
      end
    end
  end

  initial begin
    while (!sim_done) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        chk("cnt",   c, cnt[c*W +: W], m_cnt[c]);
        chk("busy",  c, busy[c],  (m_ph[c] == 1));
        chk("tc",    c, tc[c],    (m_ph[c] == 1) && (m_cnt[c] == m_n[c]));
        chk("match", c, match[c], (m_ph[c] == 1) && (m_cnt[c] == m_cmp[c]));
      end
    end
  end

  task automatic set_ch(input int c, input int nv, input int cv, input logic mv);
    n[c*W +: W]   = nv[W-1:0];
    cmp[c*W +: W] = cv[W-1:0];
    mode[c]       = mv;
  endtask

  function automatic int cnt_of(input int c);
    return int'(cnt[c*W +: W]);
  endfunction

  initial begin
    rstn = 1'b0; clr = 1'b0; exec = '0; mode = '0; n = '0; cmp = '0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      chk("rst_cnt", c, cnt_of(c), 0);
      chk("rst_busy", c, busy[c], 0);
    end
    chk("rst_tc", 0, tc, 0);
    chk("rst_match", 0, match, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Free-running wrap, n=3
    set_ch(0, 3, 1, 1'b0);
    exec[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("wrap_cnt", 0, cnt_of(0), j % 4);
      chk("wrap_tc", 0, tc[0], (j % 4) == 3);
    end
    exec[0] = 1'b0;
    @(negedge clk);

    // One-shot n=5 cmp=2
    set_ch(1, 5, 2, 1'b1);
    exec[1] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("os_cnt", 1, cnt_of(1), j);
      chk("os_match", 1, match[1], j == 2);
      chk("os_tc", 1, tc[1], j == 5);
    end
    repeat (3) begin
      @(negedge clk);
      chk("os_done_cnt", 1, cnt_of(1), 5);
      chk("os_done_busy", 1, busy[1], 0);
    end
    exec[1] = 1'b0;
    @(negedge clk);
    chk("os_idle_cnt", 1, cnt_of(1), 5);
    exec[1] = 1'b1;
    @(negedge clk);
    chk("os_restart_busy", 1, busy[1], 1);
    chk("os_restart_cnt", 1, cnt_of(1), 0);
    exec[1] = 1'b0;
    @(negedge clk);

    // Abort on the terminal cycle
    set_ch(2, 4, 9, 1'b0);
    exec[2] = 1'b1;
    for (int j = 0; j < 5; j++) @(negedge clk);
    chk("abort_tc_pre", 2, tc[2], 1);
    exec[2] = 1'b0;
    @(negedge clk);
    chk("abort_cnt", 2, cnt_of(2), 4);
    chk("abort_busy", 2, busy[2], 0);
    chk("abort_tc", 2, tc[2], 0);

    // Shadowed n: live change mid-run is ignored until restart
    set_ch(3, 7, 3, 1'b0);
    exec[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n[3*W +: W] = 8'd2;
    for (int j = 2; j < 10; j++) begin
      @(negedge clk);
      chk("shadow_old_cnt", 3, cnt_of(3), j % 8);
    end
    exec[3] = 1'b0;
    @(negedge clk);
    exec[3] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("shadow_new_cnt", 3, cnt_of(3), j % 3);
    end
    exec[3] = 1'b0;
    @(negedge clk);

    // Staggered multi-channel run, then clr
    set_ch(0, 0, 0, 1'b0);
    set_ch(1, 1, 0, 1'b0);
    set_ch(2, 4, 0, 1'b0);
    set_ch(3, 9, 0, 1'b0);
    for (int c = 0; c < CH; c++) begin
      exec[c] = 1'b1;
      @(negedge clk);
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("n0_tc", 0, tc[0], 1);
      chk("n0_cnt", 0, cnt_of(0), 0);
    end
    clr = 1'b1;
    @(negedge clk);
    chk("clr_busy", 0, busy, 0);
    chk("clr_cnt", 0, cnt, 0);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_restart_busy", 0, busy, 4'hF);
    exec = '0;
    @(negedge clk);
    mode[0] = 1'b1;
    exec[0] = 1'b1;
    @(negedge clk);
    chk("n0_shot_busy", 0, busy[0], 1);
    chk("n0_shot_tc", 0, tc[0], 1);
    @(negedge clk);
    chk("n0_shot_done", 0, busy[0], 0);
    exec[0] = 1'b0;
    @(negedge clk);

    // Asynchronous reset mid-count
    set_ch(0, 20, 30, 1'b0);
    exec[0] = 1'b1;
    for (int j = 0; j < 7; j++) @(negedge clk);
    chk("pre_rst_cnt", 0, cnt_of(0), 6);
    #2 rstn = 1'b0;
    #1;
    chk("async_cnt", 0, cnt, 0);
    chk("async_busy", 0, busy, 0);
    chk("async_tc", 0, tc, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 0, busy[0], 1);
    chk("post_rst_cnt0", 0, cnt_of(0), 0);
    @(negedge clk);
    chk("post_rst_cnt1", 0, cnt_of(0), 1);

    // Random traffic, including live parameter churn and occasional clr
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(7) == 0) exec[c] = ~exec[c];
        if ($urandom_range(3) == 0)
          set_ch(c, $urandom_range(9), $urandom_range(11), 1'($urandom_range(1)));
      end
      clr = ($urandom_range(49) == 0);
    end
    clr = 1'b0;
    exec = '0;
    repeat (2) @(negedge clk);
    sim_done = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnt_mod_multi.md
CNT_MOD_MULTI -- requirements
Module: cnt_mod_multi

Interface
REQ-001 Parameter W, default 32: counter and terminal/compare value width in bits (2..32).
REQ-002 Parameter CH, default 4: number of independent counter channels (1..16).
REQ-003 clk  input  1: single clock; all state changes occur on its rising edge.
REQ-004 rstn  input  1: reset; asynchronous assertion, active-low.
REQ-005 clr  input  1: synchronous clear of all channels.
REQ-006 exec  input  CH: per-channel run request (level).
REQ-007 mode  input  CH: per-channel mode; 0 = free-running wrap, 1 = one-shot.
REQ-008 n  input  CH*W: per-channel terminal value; channel i occupies bits [i*W +: W].
REQ-009 cmp  input  CH*W: per-channel compare value, packed like n.
REQ-010 cnt  output  CH*W: per-channel count, packed like n.
REQ-011 busy  output  CH: channel i is in state RUN.
REQ-012 tc  output  CH: terminal-count pulse.
REQ-013 match  output  CH: compare-match pulse.

Function
REQ-014 Each channel SHALL implement states IDLE, RUN, DONE, independently of the other channels.
REQ-015 IDLE and exec[i]=1 SHALL give next state RUN and cnt=0, and SHALL latch n, cmp and mode into channel shadow registers.
REQ-016 In RUN, cnt SHALL increment by 1 each cycle while exec[i]=1, using the shadow values only; live n, cmp and mode changes SHALL have no effect until the next start.
REQ-017 The count sequence SHALL be 0,1,...,n_l (period n_l+1); when cnt==n_l with mode_l=0, the next cnt SHALL be 0 and state SHALL stay RUN.
REQ-018 When cnt==n_l with mode_l=1, state SHALL go to DONE and cnt SHALL hold n_l.
REQ-019 DONE SHALL go to IDLE when exec[i]=0; cnt SHALL hold while exec[i]=1 (no retrigger without an exec low cycle).
REQ-020 exec[i]=0 in RUN SHALL give next state IDLE with cnt held (no increment); this SHALL take precedence over wrap or one-shot completion in the same cycle.
REQ-021 tc[i] SHALL equal (state==RUN && cnt==n_l), decoded from registers only, with no combinational path from any input.
REQ-022 match[i] SHALL equal (state==RUN && cnt==cmp_l), decoded from registers only.
REQ-023 n_l=0 SHALL give cnt fixed at 0 and tc high every RUN cycle (mode 0); with mode 1, RUN SHALL last one cycle.
REQ-024 cmp_l>n_l SHALL mean match is never asserted.
REQ-025 Start latency SHALL be: exec sampled high in IDLE at edge k, busy=1 and cnt=0 visible after edge k, cnt=1 after edge k+1.
REQ-026 clr=1 SHALL force every channel to IDLE with cnt=0 at the next edge, overriding exec and every other event.

Reset
REQ-027 rstn=0 SHALL immediately set every channel to IDLE and clear cnt and all shadow registers to 0.
REQ-028 While rstn=0, busy, tc and match SHALL be 0.
REQ-029 Reset deassertion SHALL be synchronised externally; the first active edge after release SHALL behave as IDLE.
REQ-030 Reset asserted mid-count SHALL discard the run; the channel SHALL not resume without an exec transition observed in IDLE.

Structure
REQ-031 Package cnt_mod_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the MODE_WRAP/MODE_ONESHOT constants.
REQ-032 Sub-module cnt_mod_ch SHALL implement one channel; cnt_mod_multi SHALL instantiate it CH times via generate and do only packing/unpacking.
REQ-033 The design SHALL contain no gated or derived clocks and no latches.

Verification
REQ-034 Wrap test: W=8, n=3, mode=0, exec high 10 cycles -> cnt 0,1,2,3,0,1,2,3,0,1; tc high on each cnt==3.
REQ-035 One-shot test: n=5, cmp=2, mode=1 -> match on cnt==2, tc on cnt==5, then DONE with cnt=5 and busy=0; restart only after an exec low cycle.
REQ-036 Abort/precedence test: exec drops on the cycle cnt==n_l -> IDLE with cnt=n_l held; tc high that cycle only.
REQ-037 Shadow test: change n from 7 to 2 mid-run -> channel still wraps at 7; the next start uses 2.
REQ-038 Multi-channel test: CH=4, channel n=0,1,4,9 started on staggered cycles -> independent sequences; clr mid-run -> all cnt=0, all busy=0 next cycle.
REQ-039 Reset test: assert rstn between clock edges at cnt=6 -> outputs zero immediately; with exec held high after release -> restart from 0 one cycle later.
